// File: rtl/ahb_bram_bridge.sv
// rtl/ahb_bram_bridge.sv - zero-wait AHB-Lite slave driving a simple dual-port block RAM
module ahb_bram_bridge #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
    output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
    input  logic [31:0]           BRAM_RDATA,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WRITE
);

    logic                  accept;
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic [3:0]            be;

    logic                  wr_pend_q, wr_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]            wr_be_q, wr_be_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic [3:0]            fwd_be_q, fwd_be_d;

    logic unused_inputs;
    assign unused_inputs = ^{HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign haddr_word = HADDR[ADDR_WIDTH+1:2];

    always_comb begin
        be = 4'b1111;
        case (HSIZE)
            3'd0:    be = 4'b0001 << HADDR[1:0];
            3'd1:    be = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        wr_pend_d   = accept & HWRITE;
        wr_addr_d   = wr_addr_q;
        wr_be_d     = wr_be_q;
        if (accept && HWRITE) begin
            wr_addr_d = haddr_word;
            wr_be_d   = be;
        end
        // The RAM reads pre-write contents when a read hits the word being written now.
        fwd_valid_d = accept & ~HWRITE & wr_pend_q & (haddr_word == wr_addr_q);
        fwd_data_d  = fwd_data_q;
        fwd_be_d    = fwd_be_q;
        if (fwd_valid_d) begin
            fwd_data_d = HWDATA;
            fwd_be_d   = wr_be_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_be_q     <= 4'b0000;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= 32'h0;
            fwd_be_q    <= 4'b0000;
        end else begin
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_be_q     <= wr_be_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            fwd_be_q    <= fwd_be_d;
        end
    end

    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
    assign BRAM_RDADDR = haddr_word;
    assign BRAM_WRADDR = wr_addr_q;
    assign BRAM_WDATA  = HWDATA;
    assign BRAM_WRITE  = wr_pend_q ? wr_be_q : 4'b0000;

    always_comb begin
        HRDATA = BRAM_RDATA;
        for (int k = 0; k < 4; k++) begin
            if (fwd_valid_q && fwd_be_q[k]) begin
                HRDATA[k*8 +: 8] = fwd_data_q[k*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// tb/tb_ahb_bram_bridge.sv - directed table-driven bench for ahb_bram_bridge
module tb_ahb_bram_bridge;

    localparam int AW = 14;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [3:0]    HPROT;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;
    logic [AW-1:0] BRAM_RDADDR;
    logic [AW-1:0] BRAM_WRADDR;
    logic [31:0]   BRAM_RDATA;
    logic [31:0]   BRAM_WDATA;
    logic [3:0]    BRAM_WRITE;

    ahb_bram_bridge #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .BRAM_RDADDR(BRAM_RDADDR),
        .BRAM_WRADDR(BRAM_WRADDR), .BRAM_RDATA(BRAM_RDATA),
        .BRAM_WDATA(BRAM_WDATA), .BRAM_WRITE(BRAM_WRITE)
    );

    always #5 HCLK = ~HCLK;

    // Block RAM stand-in: byte-enabled write port, registered read-before-write port.
    bit [31:0] mem [0:(1<<AW)-1];
    always @(posedge HCLK) begin
        for (int k = 0; k < 4; k++) begin
            if (BRAM_WRITE[k]) mem[BRAM_WRADDR][k*8 +: 8] <= BRAM_WDATA[k*8 +: 8];
        end
        BRAM_RDATA <= mem[BRAM_RDADDR];
    end

    typedef struct {
        logic        hsel;
        logic        hready;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [3:0]  exp_be;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be);
        vec_t v;
        v = '{1'b1, 1'b1, 2'b10, 1'b1, sz, a, d, be, 1'b0, 32'h0};
        return v;
    endfunction

    function automatic vec_t rd(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] e);
        vec_t v;
        v = '{1'b1, 1'b1, 2'b10, 1'b0, sz, a, 32'h0, 4'b0000, 1'b1, e};
        return v;
    endfunction

    function automatic vec_t ign(input logic s, input logic r, input logic [1:0] t);
        vec_t v;
        v = '{s, r, t, 1'b1, 3'd2, 32'h20, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0};
        return v;
    endfunction

    task automatic drive_idle();
        HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd2; HADDR = 32'h0; HPROT = 4'h0;
    endtask

    initial begin
        vecs[0]  = wr(3'd2, 32'h20,  32'hDEAD_BEEF, 4'b1111);
        vecs[1]  = ign(1'b1, 1'b1, 2'b00);
        vecs[2]  = rd(3'd2, 32'h20,  32'hDEAD_BEEF);
        vecs[3]  = wr(3'd2, 32'h40,  32'h0000_0000, 4'b1111);
        vecs[4]  = wr(3'd0, 32'h42,  32'h00AA_0000, 4'b0100);
        vecs[5]  = wr(3'd1, 32'h40,  32'h0000_1234, 4'b0011);
        vecs[6]  = ign(1'b1, 1'b1, 2'b00);
        vecs[7]  = rd(3'd2, 32'h40,  32'h00AA_1234);
        vecs[8]  = wr(3'd2, 32'h100, 32'h1111_1111, 4'b1111);
        vecs[9]  = wr(3'd0, 32'h103, 32'h5500_0000, 4'b1000);
        vecs[10] = rd(3'd2, 32'h100, 32'h5511_1111);
        vecs[11] = wr(3'd2, 32'h108, 32'h0BAD_C0DE, 4'b1111);
        vecs[12] = ign(1'b1, 1'b1, 2'b00);
        vecs[13] = wr(3'd2, 32'h104, 32'hCAFE_F00D, 4'b1111);
        vecs[14] = rd(3'd2, 32'h108, 32'h0BAD_C0DE);
        vecs[15] = ign(1'b1, 1'b1, 2'b01);
        vecs[16] = ign(1'b0, 1'b1, 2'b10);
        vecs[17] = ign(1'b1, 1'b0, 2'b10);
        vecs[18] = rd(3'd2, 32'h20,  32'hDEAD_BEEF);
        vecs[19] = rd(3'd2, 32'h104, 32'hCAFE_F00D);
        vecs[20] = rd(3'd1, 32'h42,  32'h00AA_1234);

        // Reset held with a write request on the bus.
        HRESETn = 1'b0;
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
        HSIZE = 3'd2; HADDR = 32'h20; HPROT = 4'h0; HWDATA = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge HCLK); #1;
            check("rst_bram_write", {28'h0, BRAM_WRITE}, 32'h0);
            check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
            check("rst_hresp", {31'h0, HRESP}, 32'h0);
        end
        drive_idle();
        HRESETn = 1'b1;
        @(negedge HCLK); #1;
        check("rst_no_ram_change", mem[8], 32'h0);
        check("post_rst_bram_write", {28'h0, BRAM_WRITE}, 32'h0);

        for (int i = 0; i <= NV; i++) begin
            @(negedge HCLK);
            if (i < NV) begin
                HSEL = vecs[i].hsel; HREADY = vecs[i].hready; HTRANS = vecs[i].htrans;
                HWRITE = vecs[i].hwrite; HSIZE = vecs[i].hsize; HADDR = vecs[i].haddr;
            end else begin
                drive_idle();
            end
            HWDATA = (i > 0) ? vecs[i-1].hwdata : 32'h0;
            #1;
            if (i < NV) check($sformatf("v%0d_rdaddr", i), {18'h0, BRAM_RDADDR}, {18'h0, vecs[i].haddr[15:2]});
            if (i > 0) begin
                check($sformatf("v%0d_bram_write", i-1), {28'h0, BRAM_WRITE}, {28'h0, vecs[i-1].exp_be});
                if (vecs[i-1].exp_be != 4'b0000) begin
                    check($sformatf("v%0d_wraddr", i-1), {18'h0, BRAM_WRADDR}, {18'h0, vecs[i-1].haddr[15:2]});
                    check($sformatf("v%0d_wdata", i-1), BRAM_WDATA, vecs[i-1].hwdata);
                end
                if (vecs[i-1].chk_rd) check($sformatf("v%0d_hrdata", i-1), HRDATA, vecs[i-1].exp_rdata);
            end
        end

        // Reset asserted in the middle of a write data phase aborts the write.
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h200;
        @(negedge HCLK);
        drive_idle();
        HWDATA = 32'h1234_5678;
        #1;
        check("mid_wr_be_before_rst", {28'h0, BRAM_WRITE}, 32'hF);
        HRESETn = 1'b0;
        #1;
        check("mid_wr_be_after_rst", {28'h0, BRAM_WRITE}, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        check("mid_wr_ram_untouched", mem[32'h80], 32'h0);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h200;
        @(negedge HCLK);
        drive_idle();
        #1;
        check("mid_wr_readback", HRDATA, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
